// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl -- instruction memory with a valid/ready fetch port and a
// program-load write port.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset (memory contents are kept)
//   req_valid  : fetch request present
//   req_ready  : fetch accepted this cycle (combinational)
//   req_addr   : fetch byte address, ADDR_W bits
//   rsp_valid  : fetch response present
//   rsp_ready  : consumer takes the response
//   rsp_data   : fetched word (NOP_WORD when the fetch faulted)
//   rsp_fault  : bit0 misaligned address, bit1 word index out of range
//   ld_en      : program-load write strobe
//   ld_addr    : program-load word index
//   ld_data    : program-load word
// -----------------------------------------------------------------------------
module imem_ctrl #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_WORD    = 32'h00000013,
    localparam int unsigned LD_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_fault,
    input  logic              ld_en,
    input  logic [LD_W-1:0]   ld_addr,
    input  logic [31:0]       ld_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       rsp_data_reg;
    logic [1:0]        rsp_fault_reg;

    // Power-up fill so an unloaded location executes as a harmless NOP.
    logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

    logic              accept;
    logic              capture;
    logic              ld_ok;
    logic [ADDR_W-1:0] cap_addr;
    logic [ADDR_W-3:0] cap_idx;
    logic              cap_misalign;
    logic              cap_range;
    logic              cap_bypass;

    assign req_ready = rst_n && ((state_reg == IDLE) || ((state_reg == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_fault = rsp_fault_reg;

    // Loads are dropped during reset and when the index is beyond DEPTH.
    assign ld_ok = rst_n && ld_en && (32'(ld_addr) < DEPTH);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE, RESP: begin
                if (accept) begin
                    addr_next = req_addr;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the accept edge is also the capture edge.
                        state_next = RESP;
                        capture    = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_CYCLES);
                    end
                end else if ((state_reg == RESP) && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    capture    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The capture address comes straight from the port when the fetch is
    // captured on its own accept edge, otherwise from the latched request.
    always_comb begin
        cap_addr     = (state_reg == WAIT) ? addr_reg : req_addr;
        cap_idx      = cap_addr[ADDR_W-1:2];
        cap_misalign = |cap_addr[1:0];
        cap_range    = (32'(cap_idx) >= DEPTH);
        // Write-first: a load hitting the captured index wins over the array.
        cap_bypass   = ld_ok && (32'(ld_addr) == 32'(cap_idx));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            addr_reg      <= '0;
            rsp_data_reg  <= 32'd0;
            rsp_fault_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            if (capture) begin
                rsp_fault_reg <= {cap_range, cap_misalign};
                if (cap_range || cap_misalign) begin
                    rsp_data_reg <= NOP_WORD;
                end else if (cap_bypass) begin
                    rsp_data_reg <= ld_data;
                end else begin
                    rsp_data_reg <= mem[cap_idx[LD_W-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_ctrl -- directed bench for imem_ctrl. Instance a uses one wait
// state, instance b uses none (streaming fetches).
// -----------------------------------------------------------------------------
module tb_imem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // instance a: WAIT_CYCLES = 1
    logic        rst_a, req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, ld_en_a;
    logic [13:0] req_addr_a;
    logic [31:0] rsp_data_a, ld_data_a;
    logic [1:0]  rsp_fault_a;
    logic [5:0]  ld_addr_a;

    // instance b: WAIT_CYCLES = 0
    logic        rst_b, req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, ld_en_b;
    logic [13:0] req_addr_b;
    logic [31:0] rsp_data_b, ld_data_b;
    logic [1:0]  rsp_fault_b;
    logic [5:0]  ld_addr_b;

    imem_ctrl #(.DEPTH(64), .ADDR_W(14), .WAIT_CYCLES(1), .NOP_WORD(32'h00000013)) dut_a (
        .clk(clk), .rst_n(rst_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_data(rsp_data_a), .rsp_fault(rsp_fault_a),
        .ld_en(ld_en_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a)
    );

    imem_ctrl #(.DEPTH(64), .ADDR_W(14), .WAIT_CYCLES(0), .NOP_WORD(32'h00000013)) dut_b (
        .clk(clk), .rst_n(rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_data(rsp_data_b), .rsp_fault(rsp_fault_b),
        .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [5:0] idx, input logic [31:0] data);
        ld_en_a = 1'b1; ld_addr_a = idx; ld_data_a = data;
        step();
        ld_en_a = 1'b0;
    endtask

    // Single fetch on instance a starting from IDLE; response expected in the
    // second cycle after the accept edge.
    task automatic fetch_a(input string tag, input logic [13:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_fault);
        req_valid_a = 1'b1; req_addr_a = addr; rsp_ready_a = 1'b0;
        #1 check({tag, ".req_ready"}, 32'(req_ready_a), 32'd1);
        step();
        req_valid_a = 1'b0;
        check({tag, ".wait_valid"}, 32'(rsp_valid_a), 32'd0);
        step();
        check({tag, ".rsp_valid"}, 32'(rsp_valid_a), 32'd1);
        check({tag, ".rsp_data"}, rsp_data_a, exp_data);
        check({tag, ".rsp_fault"}, 32'(rsp_fault_a), 32'(exp_fault));
        rsp_ready_a = 1'b1;
        step();
        rsp_ready_a = 1'b0;
        check({tag, ".done_valid"}, 32'(rsp_valid_a), 32'd0);
        $display("fetch a addr=%04h data=%08h fault=%0b", addr, exp_data, exp_fault);
    endtask

    initial begin
        rst_a = 1'b0; req_valid_a = 1'b1; req_addr_a = '0; rsp_ready_a = 1'b0;
        ld_en_a = 1'b1; ld_addr_a = 6'd5; ld_data_a = 32'hdeadbeef;
        rst_b = 1'b0; req_valid_b = 1'b0; req_addr_b = '0; rsp_ready_b = 1'b0;
        ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;

        // Reset with a request and a load pending: neither may take effect.
        step();
        step();
        check("rst.req_ready", 32'(req_ready_a), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst.rsp_data", rsp_data_a, 32'd0);
        check("rst.rsp_fault", 32'(rsp_fault_a), 32'd0);
        check("rst_b.req_ready", 32'(req_ready_b), 32'd0);
        ld_en_a = 1'b0; req_valid_a = 1'b0; rst_a = 1'b1;
        step();
        check("idle.req_ready", 32'(req_ready_a), 32'd1);
        check("idle.rsp_valid", 32'(rsp_valid_a), 32'd0);
        $display("reset a released");

        // Basic fetches and fault cases.
        load_a(6'd0, 32'hffe18113);
        fetch_a("f0", 14'h0000, 32'hffe18113, 2'b00);
        fetch_a("mis", 14'h0006, 32'h00000013, 2'b01);
        fetch_a("oor", 14'h0100, 32'h00000013, 2'b10);
        fetch_a("both", 14'h0103, 32'h00000013, 2'b11);
        fetch_a("rstld", 14'h0014, 32'h00000013, 2'b00);

        // Backpressure: hold rsp_ready low for 5 cycles with a new request waiting.
        req_valid_a = 1'b1; req_addr_a = 14'h0000;
        step();
        req_addr_a = 14'h0008;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall.rsp_valid", 32'(rsp_valid_a), 32'd1);
            check("stall.rsp_data", rsp_data_a, 32'hffe18113);
            check("stall.req_ready", 32'(req_ready_a), 32'd0);
            step();
        end
        req_valid_a = 1'b0; rsp_ready_a = 1'b1;
        #1 check("release.req_ready", 32'(req_ready_a), 32'd1);
        step();
        rsp_ready_a = 1'b0;
        check("release.valid0", 32'(rsp_valid_a), 32'd0);
        step();
        check("release.valid1", 32'(rsp_valid_a), 32'd0);
        $display("stall of 5 cycles then one handshake");

        // Load on the capture edge of a fetch to the same index.
        req_valid_a = 1'b1; req_addr_a = 14'h000c;
        step();
        req_valid_a = 1'b0;
        ld_en_a = 1'b1; ld_addr_a = 6'd3; ld_data_a = 32'h00008297;
        step();
        ld_en_a = 1'b0;
        check("wfirst.rsp_valid", 32'(rsp_valid_a), 32'd1);
        check("wfirst.rsp_data", rsp_data_a, 32'h00008297);
        rsp_ready_a = 1'b1;
        step();
        rsp_ready_a = 1'b0;
        $display("write-first capture data=%08h", rsp_data_a);
        fetch_a("wfirst.re", 14'h000c, 32'h00008297, 2'b00);

        // Reset while the fetch is in WAIT.
        req_valid_a = 1'b1; req_addr_a = 14'h000c;
        step();
        req_valid_a = 1'b0; rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("wrst.rsp_valid", 32'(rsp_valid_a), 32'd0);
            check("wrst.rsp_data", rsp_data_a, 32'd0);
            step();
        end
        $display("reset during WAIT discarded the fetch");
        fetch_a("wrst.f0", 14'h0000, 32'hffe18113, 2'b00);
        fetch_a("wrst.fc", 14'h000c, 32'h00008297, 2'b00);

        // Instance b: zero wait states, streaming fetches.
        rst_b = 1'b1;
        step();
        ld_en_b = 1'b1; ld_addr_b = 6'd0; ld_data_b = 32'h11111111;
        step();
        ld_addr_b = 6'd1; ld_data_b = 32'h22222222;
        step();
        ld_addr_b = 6'd2; ld_data_b = 32'h33333333;
        step();
        ld_en_b = 1'b0;
        req_valid_b = 1'b1; rsp_ready_b = 1'b1; req_addr_b = 14'h0000;
        #1 check("stream.ready0", 32'(req_ready_b), 32'd1);
        step();
        check("stream.valid0", 32'(rsp_valid_b), 32'd1);
        check("stream.data0", rsp_data_b, 32'h11111111);
        $display("stream b data=%08h", rsp_data_b);
        req_addr_b = 14'h0004;
        #1 check("stream.ready1", 32'(req_ready_b), 32'd1);
        step();
        check("stream.valid1", 32'(rsp_valid_b), 32'd1);
        check("stream.data1", rsp_data_b, 32'h22222222);
        $display("stream b data=%08h", rsp_data_b);
        req_addr_b = 14'h0008;
        #1 check("stream.ready2", 32'(req_ready_b), 32'd1);
        step();
        check("stream.valid2", 32'(rsp_valid_b), 32'd1);
        check("stream.data2", rsp_data_b, 32'h33333333);
        check("stream.fault2", 32'(rsp_fault_b), 32'd0);
        $display("stream b data=%08h", rsp_data_b);
        req_valid_b = 1'b0;
        #1 check("stream.ready3", 32'(req_ready_b), 32'd1);
        step();
        check("stream.idle", 32'(rsp_valid_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit instruction words held.
REQ-002 Parameter ADDR_W, default 14: byte-address width of the fetch port.
REQ-003 Parameter WAIT_CYCLES, default 1 (range 0..15): extra read wait states per fetch.
REQ-004 Parameter NOP_WORD, default 32'h00000013: word returned on a faulted fetch and used as the power-up fill.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port rst_n  input  1: reset, synchronous, active-low.
REQ-007 Port req_valid  input  1: fetch request present.
REQ-008 Port req_ready  output  1: block accepts a fetch this cycle.
REQ-009 Port req_addr  input  ADDR_W: fetch byte address.
REQ-010 Port rsp_valid  output  1: fetch response present.
REQ-011 Port rsp_ready  input  1: consumer accepts the response.
REQ-012 Port rsp_data  output  32: fetched instruction word.
REQ-013 Port rsp_fault  output  2: bit0 = misaligned, bit1 = out of range.
REQ-014 Port ld_en  input  1: program-load write strobe.
REQ-015 Port ld_addr  input  clog2(DEPTH): program-load word index.
REQ-016 Port ld_data  input  32: program-load word.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-018 A fetch SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, latching req_addr.
REQ-019 req_ready SHALL be combinational: 1 in IDLE, 1 in RESP when rsp_ready=1, and 0 otherwise.
REQ-020 On accept, the FSM SHALL go to WAIT when WAIT_CYCLES>0, loading a down-counter with WAIT_CYCLES, or to RESP directly when WAIT_CYCLES=0.
REQ-021 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter reaches 1.
REQ-022 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-023 The word SHALL be captured into rsp_data on the edge entering RESP, and rsp_data/rsp_fault SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-024 In RESP, rsp_ready=1 with req_valid=0 SHALL return the FSM to IDLE and clear rsp_valid.
REQ-025 In RESP, rsp_ready=1 with req_valid=1 SHALL accept the new fetch on the same edge (back-to-back; one fetch per cycle when WAIT_CYCLES=0).
REQ-026 req_addr[1:0]!=0 SHALL set rsp_fault[0].
REQ-027 req_addr[ADDR_W-1:2] >= DEPTH SHALL set rsp_fault[1].
REQ-028 Any fault bit set SHALL force rsp_data = NOP_WORD with no memory read.
REQ-029 A non-faulted fetch SHALL return the word at index req_addr[ADDR_W-1:2].
REQ-030 ld_en=1 SHALL write ld_data at ld_addr on the edge, in any FSM state.
REQ-031 ld_en=1 with ld_addr >= DEPTH SHALL be ignored.
REQ-032 A load to the same index on the capture edge SHALL make the fetch return the new ld_data (write-first).
REQ-033 Memory SHALL initialise to NOP_WORD in every entry at power-up.

Reset
REQ-034 rst_n=0 at an edge SHALL force state IDLE, rsp_valid=0, rsp_data=0, rsp_fault=0 and wait counter=0.
REQ-035 While rst_n=0, req_ready SHALL be 0 and no fetch SHALL be accepted.
REQ-036 Reset in WAIT or RESP SHALL discard the pending fetch, producing no response after reset.
REQ-037 Reset SHALL NOT alter memory contents.
REQ-038 ld_en SHALL be ignored while rst_n=0.

Verification
REQ-039 WAIT_CYCLES=1: load 32'hffe18113 at index 0, fetch addr 0 -> rsp_valid 2 cycles after accept, data ffe18113, fault 00.
REQ-040 Fetch addr 0x6 -> data 00000013, fault 01; fetch addr 0x100 with DEPTH=64 -> data 00000013, fault 10.
REQ-041 WAIT_CYCLES=0: req_valid held, rsp_ready=1, addrs 0,4,8 -> three responses on consecutive cycles, req_ready continuously 1.
REQ-042 Hold rsp_ready=0 for 5 cycles -> rsp_data stable, req_ready=0; then release -> exactly one handshake.
REQ-043 Load 32'h00008297 at index 3 on the capture edge of a fetch to 0xC -> data 00008297.
REQ-044 Assert rst_n=0 during WAIT -> no rsp_valid afterwards; a refetch of a previously loaded word returns the same value.
